// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module  : uart_rx_pkg
// Brief   : Baud divisor constants and receiver state encoding for uart_rx.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  // System clocks per bit at the supported line rates
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 312;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_baudgen.sv
// ============================================================================
// Module  : baudgen_rx
// Brief   : Receive baud timer; first tick at half a bit after clear, then
//           one tick per bit period.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module baudgen_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int W = (BAUD > 2) ? $clog2(BAUD) : 1;
  localparam logic [W-1:0] HALF_M1 = W'(BAUD / 2 - 1);
  localparam logic [W-1:0] FULL_M1 = W'(BAUD - 1);

  logic [W-1:0] cnt;
  logic         first;

  assign tick = en && (cnt == (first ? HALF_M1 : FULL_M1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      first <= 1'b1;
    end else if (en) begin
      if (tick) begin
        cnt   <= '0;
        first <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 serial receiver with mid-bit sampling, byte strobe and
//           framing-error strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD = B115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       busy
);

  logic [1:0] sync;
  logic       rx_s;
  logic       armed;
  rx_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic       tick;
  logic       timer_clear;

  assign rx_s = sync[1];

  // Synchronizer resets low so a line must be seen high before arming
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  // The timer only runs while a frame is being clocked in
  assign timer_clear = (state == IDLE) || (state == BREAK);

  baudgen_rx #(
    .BAUD(BAUD)
  ) u_baudgen (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .en   (!timer_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      armed  <= 1'b0;
      shreg  <= 8'h00;
      bitcnt <= 3'd0;
      data   <= 8'h00;
      rcv    <= 1'b0;
      ferr   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      rcv  <= 1'b0;
      ferr <= 1'b0;
      if (rx_s) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state  <= DATA;
              bitcnt <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shreg  <= {rx_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            busy <= 1'b0;
            if (rx_s) begin
              data  <= shreg;
              rcv   <= 1'b1;
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int BAUD = B115200;
  localparam int LAT  = 2 + BAUD / 2 + 9 * BAUD + 1;
  localparam int FRAME = 10 * BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b0;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  uart_rx #(.BAUD(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .data(data),
    .rcv (rcv),
    .ferr(ferr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Observed strobes, logged away from the active edge
  int unsigned rcv_t[$];
  logic [7:0]  rcv_d[$];
  int unsigned ferr_t[$];
  int          both = 0;
  int          busy_bad = 0;

  // Frame-level model state
  int unsigned exp_t[$];
  logic [7:0]  exp_d[$];
  logic [7:0]  exp_data = 8'h00;

  always @(negedge clk) begin
    if (rcv) begin
      rcv_t.push_back(cyc);
      rcv_d.push_back(data);
    end
    if (ferr) ferr_t.push_back(cyc);
    if (rcv && ferr) both++;
    if ((rcv || ferr) && busy) busy_bad++;
  end

  task automatic clear_obs();
    rcv_t.delete(); rcv_d.delete(); ferr_t.delete();
    exp_t.delete(); exp_d.delete();
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Line-level transmitter: start, 8 data LSB first, stop; t0 = start edge cycle
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int unsigned t0);
    logic [9:0] f;
    f  = {stop_bit, b, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) line(f[i], BAUD);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data); end
    tests++; if (rcv !== 1'b0) begin fails++; $display("FAIL reset_rcv: got %b expected 0", rcv); end
    tests++; if (ferr !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    line(1'b0, 200);
    tests++;
    if (busy !== 1'b0 || rcv_t.size() != 0 || ferr_t.size() != 0) begin
      fails++;
      $display("FAIL low_line_after_reset: busy=%b rcv_n=%0d ferr_n=%0d expected 0/0/0",
               busy, rcv_t.size(), ferr_t.size());
    end
    line(1'b1, 10);
    clear_obs();
  endtask

  task automatic test_single();
    int unsigned t0;
    send_frame(8'h55, 1'b1, t0);
    exp_data = 8'h55;
    line(1'b1, 10);
    tests++;
    if (rcv_t.size() != 1) begin
      fails++; $display("FAIL single_count: got %0d expected 1", rcv_t.size());
    end else begin
      tests++; if (rcv_t[0] != t0 + LAT) begin fails++; $display("FAIL single_latency: got %0d expected %0d", rcv_t[0] - t0, LAT); end
      tests++; if (rcv_d[0] !== 8'h55) begin fails++; $display("FAIL single_data: got %h expected 55", rcv_d[0]); end
    end
    tests++; if (ferr_t.size() != 0) begin fails++; $display("FAIL single_ferr: got %0d expected 0", ferr_t.size()); end
    tests++; if (data !== 8'h55) begin fails++; $display("FAIL single_hold: got %h expected 55", data); end
    clear_obs();
  endtask

  task automatic test_back_to_back();
    int unsigned t0, t1;
    send_frame(8'h41, 1'b1, t0);
    send_frame(8'h42, 1'b1, t1);
    exp_data = 8'h42;
    line(1'b1, 10);
    tests++;
    if (rcv_t.size() != 2) begin
      fails++; $display("FAIL b2b_count: got %0d expected 2", rcv_t.size());
    end else begin
      tests++; if (rcv_t[0] != t0 + LAT) begin fails++; $display("FAIL b2b_latency: got %0d expected %0d", rcv_t[0] - t0, LAT); end
      tests++; if (rcv_t[1] - rcv_t[0] != FRAME) begin fails++; $display("FAIL b2b_spacing: got %0d expected %0d", rcv_t[1] - rcv_t[0], FRAME); end
      tests++; if (rcv_d[0] !== 8'h41 || rcv_d[1] !== 8'h42) begin fails++; $display("FAIL b2b_data: got %h,%h expected 41,42", rcv_d[0], rcv_d[1]); end
    end
    clear_obs();
  endtask

  task automatic test_glitch();
    line(1'b0, 20);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
    line(1'b1, 100);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
    tests++;
    if (rcv_t.size() != 0 || ferr_t.size() != 0 || data !== exp_data) begin
      fails++;
      $display("FAIL glitch_quiet: rcv_n=%0d ferr_n=%0d data=%h expected 0/0/%h",
               rcv_t.size(), ferr_t.size(), data, exp_data);
    end
    clear_obs();
  endtask

  task automatic test_framing_error();
    int unsigned t0, t1;
    send_frame(8'hA3, 1'b0, t0);
    line(1'b0, 1500);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_break_busy: got %b expected 0", busy); end
    line(1'b0, 1500);
    tests++;
    if (ferr_t.size() != 1) begin
      fails++; $display("FAIL ferr_count: got %0d expected 1", ferr_t.size());
    end else begin
      tests++; if (ferr_t[0] != t0 + LAT) begin fails++; $display("FAIL ferr_latency: got %0d expected %0d", ferr_t[0] - t0, LAT); end
    end
    tests++;
    if (rcv_t.size() != 0 || data !== exp_data) begin
      fails++; $display("FAIL ferr_data_hold: rcv_n=%0d data=%h expected 0/%h", rcv_t.size(), data, exp_data);
    end
    line(1'b1, 20);
    clear_obs();
    send_frame(8'h0F, 1'b1, t1);
    exp_data = 8'h0F;
    line(1'b1, 10);
    tests++;
    if (rcv_t.size() != 1 || ferr_t.size() != 0) begin
      fails++; $display("FAIL ferr_recover_count: rcv_n=%0d ferr_n=%0d expected 1/0", rcv_t.size(), ferr_t.size());
    end else begin
      tests++; if (rcv_d[0] !== 8'h0F || rcv_t[0] != t1 + LAT) begin fails++; $display("FAIL ferr_recover_data: got %h@%0d expected 0f@%0d", rcv_d[0], rcv_t[0] - t1, LAT); end
    end
    clear_obs();
  endtask

  task automatic test_reset_midframe();
    int unsigned t0;
    line(1'b0, BAUD);
    line(1'b1, 4 * BAUD + BAUD / 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_data = 8'h00;
    tests++;
    if (data !== 8'h00 || rcv !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midframe_reset_outputs: data=%h rcv=%b ferr=%b busy=%b expected 00/0/0/0", data, rcv, ferr, busy);
    end
    line(1'b1, 5 * BAUD);
    tests++;
    if (rcv_t.size() != 0 || ferr_t.size() != 0) begin
      fails++; $display("FAIL midframe_no_strobe: rcv_n=%0d ferr_n=%0d expected 0/0", rcv_t.size(), ferr_t.size());
    end
    send_frame(8'h3C, 1'b1, t0);
    exp_data = 8'h3C;
    line(1'b1, 10);
    tests++;
    if (rcv_t.size() != 1) begin
      fails++; $display("FAIL midframe_next_count: got %0d expected 1", rcv_t.size());
    end else begin
      tests++; if (rcv_d[0] !== 8'h3C) begin fails++; $display("FAIL midframe_next_data: got %h expected 3c", rcv_d[0]); end
    end
    clear_obs();
  endtask

  // Transmitter-style loopback: one configured character sent three times
  task automatic test_loopback();
    logic [7:0]  ch;
    int unsigned t0;
    ch = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      send_frame(ch, 1'b1, t0);
      exp_t.push_back(t0 + LAT);
    end
    exp_data = ch;
    line(1'b1, 10);
    tests++;
    if (rcv_t.size() != 3 || ferr_t.size() != 0) begin
      fails++; $display("FAIL loopback_count: rcv_n=%0d ferr_n=%0d expected 3/0", rcv_t.size(), ferr_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (rcv_d[i] !== ch || rcv_t[i] != exp_t[i]) begin
          fails++; $display("FAIL loopback_char%0d: got %h@%0d expected %h@%0d", i, rcv_d[i], rcv_t[i], ch, exp_t[i]);
        end
      end
    end
    clear_obs();
  endtask

  task automatic test_random_stream();
    logic [7:0]  b;
    int unsigned t0;
    for (int i = 0; i < 8; i++) begin
      line(1'b1, $urandom_range(0, 2 * BAUD));
      b = 8'($urandom);
      send_frame(b, 1'b1, t0);
      exp_t.push_back(t0 + LAT);
      exp_d.push_back(b);
      exp_data = b;
    end
    line(1'b1, 10);
    tests++;
    if (rcv_t.size() != exp_t.size()) begin
      fails++; $display("FAIL random_count: got %0d expected %0d", rcv_t.size(), exp_t.size());
    end else begin
      for (int i = 0; i < exp_t.size(); i++) begin
        tests++;
        if (rcv_d[i] !== exp_d[i] || rcv_t[i] != exp_t[i]) begin
          fails++; $display("FAIL random_frame%0d: got %h@%0d expected %h@%0d", i, rcv_d[i], rcv_t[i], exp_d[i], exp_t[i]);
        end
      end
    end
    tests++; if (data !== exp_data) begin fails++; $display("FAIL random_hold: got %h expected %h", data, exp_data); end
    clear_obs();
  endtask

  task automatic test_invariants();
    tests++; if (both != 0) begin fails++; $display("FAIL rcv_ferr_overlap: got %0d expected 0", both); end
    tests++; if (busy_bad != 0) begin fails++; $display("FAIL busy_with_strobe: got %0d expected 0", busy_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_midframe();
    test_loopback();
    test_random_stream();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
